// File: rtl/fifo_tx_if.sv
// FIFO read-side bundle between the processor-side 4x8 FIFO and the serial transmitter.
// Valid/ready: rdReq is a one-cycle pop; wordIn is valid the cycle after rdReq and nempty qualifies a pop.
interface fifo_tx_if;
  logic       nempty;
  logic [7:0] wordIn;
  logic       rdReq;

  modport master (input nempty, input wordIn, output rdReq);
  modport slave  (output nempty, output wordIn, input rdReq);
endinterface

// File: rtl/fifo_tx.sv
// Serial transmitter draining an 8-bit FIFO: start, 8 data bits LSB-first, optional parity, stop.
// Optional even-parity bit enabled by defining FIFO_TX_PARITY_EN.
module fifo_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            pclk,
  input  logic            clear,
  input  logic            txEn,
  fifo_tx_if.master       fifo,
  output logic            txd,
  output logic            busy,
  output logic            txDone,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef FIFO_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_t;

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       rdreq_q, rdreq_d;
  logic       done_q, done_d;
  logic       bit_end;
`ifdef FIFO_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef FIFO_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE:  if (txEn && fifo.nempty) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // Capture is unconditional: the pop was already issued in FETCH.
        shift_d = fifo.wordIn;
`ifdef FIFO_TX_PARITY_EN
        par_d   = ^fifo.wordIn;
`endif
        cnt_d   = 8'd0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
`ifdef FIFO_TX_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_STOP;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef FIFO_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          state_d = (txEn && fifo.nempty) ? S_FETCH : S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so every output leaves a flop.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef FIFO_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
    rdreq_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (cnt_d == LAST);
  end

  always_ff @(posedge pclk) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      rdreq_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      rdreq_q <= rdreq_d;
      done_q  <= done_d;
`ifdef FIFO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign fifo.rdReq  = rdreq_q;
  assign txd         = txd_q;
  assign busy        = busy_q;
  assign txDone      = done_q;
  assign dbg_state_o = state_q;

endmodule
